// File: rtl/shiftreg_chain.sv
// Drives a daisy-chain of N_BYTES 74HC595 devices: serialises a W-bit word onto SER/SRCLK, then pulses RCLK.
// Optional output-enable port o_OE_n is built when the macro SHIFTREG_OE_EN is defined.
`timescale 1ns/1ps

module shiftreg_chain #(
    parameter int N_BYTES   = 1,
    parameter int CLK_DIV   = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [8*N_BYTES-1:0]   i_Data,
    input  logic                   i_Enable,
    output logic                   o_Ready,
    output logic                   o_SRCLK,
    output logic                   o_RCLK,
    output logic                   o_SER
`ifdef SHIFTREG_OE_EN
    ,
    output logic                   o_OE_n
`endif
);

    localparam int W     = 8 * N_BYTES;
    localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [W-1:0]     shift_q, shift_d;
    logic             ready_q, ready_d;
    logic             srclk_q, srclk_d;
    logic             rclk_q,  rclk_d;
    logic             ser_q,   ser_d;

    logic             div_last;
    logic [W-1:0]     shift_adv;

    // Bit presented on SER: the end of the shifter that leaves first.
    function automatic logic pick_bit(input logic [W-1:0] v);
        if (LSB_FIRST != 0) begin
            return v[0];
        end else begin
            return v[W-1];
        end
    endfunction

    assign div_last  = (div_q == DIV_LAST);
    assign shift_adv = (LSB_FIRST != 0) ? {1'b0, shift_q[W-1:1]} : {shift_q[W-2:0], 1'b0};

    // Next-state and next-output logic for the serialiser FSM.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ready_d = ready_q;
        srclk_d = srclk_q;
        rclk_d  = rclk_q;
        ser_d   = ser_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                srclk_d = 1'b0;
                rclk_d  = 1'b0;
                ser_d   = 1'b0;
                if (i_Enable && ready_q) begin
                    shift_d = i_Data;
                    bit_d   = {BIT_W{1'b0}};
                    div_d   = {DIV_W{1'b0}};
                    ready_d = 1'b0;
                    ser_d   = pick_bit(i_Data);
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_d   = {DIV_W{1'b0}};
                    srclk_d = 1'b1;
                    state_d = HIGH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_d   = {DIV_W{1'b0}};
                    srclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        rclk_d  = 1'b1;
                        state_d = LATCH;
                    end else begin
                        shift_d = shift_adv;
                        ser_d   = pick_bit(shift_adv);
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = SETUP;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_d   = {DIV_W{1'b0}};
                    rclk_d  = 1'b0;
                    ser_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                div_d   = {DIV_W{1'b0}};
                bit_d   = {BIT_W{1'b0}};
                ready_d = 1'b1;
                srclk_d = 1'b0;
                rclk_d  = 1'b0;
                ser_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            div_q   <= {DIV_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            shift_q <= {W{1'b0}};
            ready_q <= 1'b1;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
            ser_q   <= ser_d;
        end
    end

    assign o_Ready = ready_q;
    assign o_SRCLK = srclk_q;
    assign o_RCLK  = rclk_q;
    assign o_SER   = ser_q;

`ifdef SHIFTREG_OE_EN
    logic oe_n_q, oe_n_d;

    // Unblank the 595 outputs once the first complete word has been latched.
    always_comb begin
        oe_n_d = oe_n_q;
        if ((state_q == LATCH) && div_last) begin
            oe_n_d = 1'b0;
        end else begin
            oe_n_d = oe_n_q;
        end
    end

    // Output-enable register; only reset re-blanks the outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            oe_n_q <= 1'b1;
        end else begin
            oe_n_q <= oe_n_d;
        end
    end

    assign o_OE_n = oe_n_q;
`endif

endmodule

// File: tb/tb_shiftreg_chain.sv
// Self-checking bench for shiftreg_chain: an 8-bit MSB-first instance and a 24-bit LSB-first instance.
`timescale 1ns/1ps

module tb_shiftreg_chain;

    localparam int WA = 8;
    localparam int DA = 1;
    localparam int WB = 24;
    localparam int DB = 4;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_latch;
        int         exp_busy;
        int         exp_rises;
    } vec_a_t;

    typedef struct {
        logic [23:0] data;
        logic [23:0] exp_latch;
        int          exp_busy;
        int          exp_rises;
    } vec_b_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a  = 1'b0;
    logic [7:0]  data_a = 8'h00;
    logic        en_b  = 1'b0;
    logic [23:0] data_b = 24'h000000;
    logic        ready_a, srclk_a, rclk_a, ser_a, oe_a;
    logic        ready_b, srclk_b, rclk_b, ser_b, oe_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shiftreg_chain #(.N_BYTES(1), .CLK_DIV(DA), .LSB_FIRST(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_Data(data_a), .i_Enable(en_a),
        .o_Ready(ready_a), .o_SRCLK(srclk_a), .o_RCLK(rclk_a), .o_SER(ser_a)
`ifdef SHIFTREG_OE_EN
        , .o_OE_n(oe_a)
`endif
    );

    shiftreg_chain #(.N_BYTES(3), .CLK_DIV(DB), .LSB_FIRST(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_Data(data_b), .i_Enable(en_b),
        .o_Ready(ready_b), .o_SRCLK(srclk_b), .o_RCLK(rclk_b), .o_SER(ser_b)
`ifdef SHIFTREG_OE_EN
        , .o_OE_n(oe_b)
`endif
    );

`ifndef SHIFTREG_OE_EN
    assign oe_a = 1'b0;
    assign oe_b = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: expected SER bits and latched words, pushed at drive time.
    bit          exp_bits_a[$];
    logic [7:0]  exp_latch_a[$];
    bit          exp_bits_b[$];
    logic [23:0] exp_latch_b[$];

    logic        prev_srclk_a = 1'b0, prev_rclk_a = 1'b0, prev_ser_a = 1'b0;
    logic [7:0]  chain_a = 8'h00, latch_a = 8'h00;
    int          srclk_cnt_a = 0, rclk_cnt_a = 0, busy_a = 0, overlap_a = 0, phase_err_a = 0;
    int          hi_run_a = 0, rc_run_a = 0, ser_run_a = 0, since_rise_a = 0;

    logic        prev_srclk_b = 1'b0, prev_rclk_b = 1'b0, prev_ser_b = 1'b0;
    logic [23:0] chain_b = 24'h0, latch_b = 24'h0;
    int          srclk_cnt_b = 0, rclk_cnt_b = 0, busy_b = 0, overlap_b = 0, phase_err_b = 0;
    int          hi_run_b = 0, rc_run_b = 0, ser_run_b = 0, since_rise_b = 0;

    // Model of the 8-bit chain: each SRCLK rise shifts SER in at bit 0.
    initial begin : mon_a
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_srclk_a = 1'b0; prev_rclk_a = 1'b0; prev_ser_a = ser_a;
                hi_run_a = 0; rc_run_a = 0; ser_run_a = 0; since_rise_a = 0;
            end else begin
                if (!ready_a) busy_a++;
                if (srclk_a && rclk_a) overlap_a++;
                if (ser_a == prev_ser_a) ser_run_a++; else ser_run_a = 1;
                since_rise_a++;
                if (srclk_a && prev_srclk_a && (ser_a != prev_ser_a)) phase_err_a++;
                if (srclk_a && !prev_srclk_a) begin
                    srclk_cnt_a++;
                    since_rise_a = 0;
                    if (ser_run_a <= DA) phase_err_a++;
                    chk("a_bit_expected", 32'(exp_bits_a.size() > 0), 32'd1);
                    if (exp_bits_a.size() > 0) chk("a_ser_bit", 32'(ser_a), 32'(exp_bits_a.pop_front()));
                    chain_a = {chain_a[6:0], ser_a};
                end
                if (srclk_a) hi_run_a++;
                else begin
                    if (prev_srclk_a && hi_run_a != DA) phase_err_a++;
                    hi_run_a = 0;
                end
                if (rclk_a && !prev_rclk_a) begin
                    rclk_cnt_a++;
                    if (since_rise_a != DA) phase_err_a++;
                    latch_a = chain_a;
                    chk("a_latch_expected", 32'(exp_latch_a.size() > 0), 32'd1);
                    if (exp_latch_a.size() > 0) chk("a_latch_word", 32'(latch_a), 32'(exp_latch_a.pop_front()));
                end
                if (rclk_a) rc_run_a++;
                else begin
                    if (prev_rclk_a && rc_run_a != DA) phase_err_a++;
                    rc_run_a = 0;
                end
`ifdef SHIFTREG_OE_EN
                if (prev_rclk_a && !rclk_a) chk("a_oe_at_latch_fall", 32'(oe_a), 32'd0);
`endif
                prev_srclk_a = srclk_a; prev_rclk_a = rclk_a; prev_ser_a = ser_a;
            end
        end
    end

    // Model of the 24-bit chain, wired so the first (LSB) bit ends in bit 0.
    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_srclk_b = 1'b0; prev_rclk_b = 1'b0; prev_ser_b = ser_b;
                hi_run_b = 0; rc_run_b = 0; ser_run_b = 0; since_rise_b = 0;
            end else begin
                if (!ready_b) busy_b++;
                if (srclk_b && rclk_b) overlap_b++;
                if (ser_b == prev_ser_b) ser_run_b++; else ser_run_b = 1;
                since_rise_b++;
                if (srclk_b && prev_srclk_b && (ser_b != prev_ser_b)) phase_err_b++;
                if (srclk_b && !prev_srclk_b) begin
                    srclk_cnt_b++;
                    since_rise_b = 0;
                    if (ser_run_b <= DB) phase_err_b++;
                    chk("b_bit_expected", 32'(exp_bits_b.size() > 0), 32'd1);
                    if (exp_bits_b.size() > 0) chk("b_ser_bit", 32'(ser_b), 32'(exp_bits_b.pop_front()));
                    chain_b = {ser_b, chain_b[23:1]};
                end
                if (srclk_b) hi_run_b++;
                else begin
                    if (prev_srclk_b && hi_run_b != DB) phase_err_b++;
                    hi_run_b = 0;
                end
                if (rclk_b && !prev_rclk_b) begin
                    rclk_cnt_b++;
                    if (since_rise_b != DB) phase_err_b++;
                    latch_b = chain_b;
                    chk("b_latch_expected", 32'(exp_latch_b.size() > 0), 32'd1);
                    if (exp_latch_b.size() > 0) chk("b_latch_word", 32'(latch_b), 32'(exp_latch_b.pop_front()));
                end
                if (rclk_b) rc_run_b++;
                else begin
                    if (prev_rclk_b && rc_run_b != DB) phase_err_b++;
                    rc_run_b = 0;
                end
`ifdef SHIFTREG_OE_EN
                if (prev_rclk_b && !rclk_b) chk("b_oe_at_latch_fall", 32'(oe_b), 32'd0);
`endif
                prev_srclk_b = srclk_b; prev_rclk_b = rclk_b; prev_ser_b = ser_b;
            end
        end
    end

    task automatic push_a(input logic [7:0] d);
        for (int i = WA - 1; i >= 0; i--) exp_bits_a.push_back(d[i]);
        exp_latch_a.push_back(d);
    endtask

    task automatic push_b(input logic [23:0] d);
        for (int i = 0; i < WB; i++) exp_bits_b.push_back(d[i]);
        exp_latch_b.push_back(d);
    endtask

    // Called at posedge+1 with the DUT idle; the request is accepted at the next edge.
    task automatic frame_a(input logic [7:0] d);
        push_a(d);
        en_a = 1'b1; data_a = d;
        @(posedge clk); #1;
        en_a = 1'b0; data_a = ~d;
        chk("a_ready_drop", 32'(ready_a), 32'd0);
    endtask

    task automatic frame_b(input logic [23:0] d);
        push_b(d);
        en_b = 1'b1; data_b = d;
        @(posedge clk); #1;
        en_b = 1'b0; data_b = ~d;
        chk("b_ready_drop", 32'(ready_b), 32'd0);
    endtask

    task automatic wait_ready_a(input int budget, input string name);
        int c = 0;
        while (!ready_a && c < budget) begin @(posedge clk); #1; c++; end
        chk({name, "_ready_return"}, 32'(ready_a), 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic wait_ready_b(input int budget, input string name);
        int c = 0;
        while (!ready_b && c < budget) begin @(posedge clk); #1; c++; end
        chk({name, "_ready_return"}, 32'(ready_b), 32'd1);
        @(negedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin : stim
        vec_a_t va[6];
        vec_b_t vb[2];
        int s0, r0, b0, c;
        logic [7:0] kept;

        va[0] = '{8'hA5, 8'hA5, 17, 8};
        va[1] = '{8'h00, 8'h00, 17, 8};
        va[2] = '{8'hFF, 8'hFF, 17, 8};
        va[3] = '{8'h01, 8'h01, 17, 8};
        va[4] = '{8'h80, 8'h80, 17, 8};
        va[5] = '{8'h3C, 8'h3C, 17, 8};
        vb[0] = '{24'h0F00F1, 24'h0F00F1, 196, 24};
        vb[1] = '{24'hC35A96, 24'hC35A96, 196, 24};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", 32'(ready_a), 32'd1);
        chk("rst_a_srclk", 32'(srclk_a), 32'd0);
        chk("rst_a_rclk",  32'(rclk_a),  32'd0);
        chk("rst_a_ser",   32'(ser_a),   32'd0);
        chk("rst_b_ready", 32'(ready_b), 32'd1);
        chk("rst_b_srclk", 32'(srclk_b), 32'd0);
`ifdef SHIFTREG_OE_EN
        chk("rst_a_oe", 32'(oe_a), 32'd1);
        chk("rst_b_oe", 32'(oe_b), 32'd1);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            s0 = srclk_cnt_a; r0 = rclk_cnt_a; b0 = busy_a;
            frame_a(va[i].data);
            wait_ready_a(100, "a_vec");
            chk("a_vec_busy",   32'(busy_a - b0),      32'(va[i].exp_busy));
            chk("a_vec_rises",  32'(srclk_cnt_a - s0), 32'(va[i].exp_rises));
            chk("a_vec_rclk",   32'(rclk_cnt_a - r0),  32'd1);
            chk("a_vec_latch",  32'(latch_a),          32'(va[i].exp_latch));
`ifdef SHIFTREG_OE_EN
            chk("a_vec_oe", 32'(oe_a), 32'd0);
`endif
        end

        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            s0 = srclk_cnt_b; r0 = rclk_cnt_b; b0 = busy_b;
            frame_b(vb[i].data);
            wait_ready_b(400, "b_vec");
            chk("b_vec_busy",  32'(busy_b - b0),      32'(vb[i].exp_busy));
            chk("b_vec_rises", 32'(srclk_cnt_b - s0), 32'(vb[i].exp_rises));
            chk("b_vec_rclk",  32'(rclk_cnt_b - r0),  32'd1);
            chk("b_vec_latch", 32'(latch_b),          32'(vb[i].exp_latch));
        end

        // Enable held high across two frames; toggles while busy must be ignored.
        @(posedge clk); #1;
        s0 = srclk_cnt_a; r0 = rclk_cnt_a; b0 = busy_a;
        push_a(8'h01);
        en_a = 1'b1; data_a = 8'h01;
        @(posedge clk); #1;
        chk("b2b_accept1", 32'(ready_a), 32'd0);
        data_a = 8'h80;
        push_a(8'h80);
        c = 0;
        while (!ready_a && c < 100) begin @(posedge clk); #1; c++; end
        chk("b2b_ready_between", 32'(ready_a), 32'd1);
        @(posedge clk); #1;
        chk("b2b_one_idle_cycle", 32'(ready_a), 32'd0);
        for (int k = 0; k < 6; k++) begin
            data_a = 8'hFF;
            en_a = k[0];
            @(posedge clk); #1;
        end
        en_a = 1'b0;
        wait_ready_a(100, "b2b");
        chk("b2b_rclk",  32'(rclk_cnt_a - r0),  32'd2);
        chk("b2b_rises", 32'(srclk_cnt_a - s0), 32'd16);
        chk("b2b_busy",  32'(busy_a - b0),      32'd34);
        chk("b2b_latch", 32'(latch_a),          32'h80);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_no_extra_frame", 32'(rclk_cnt_a - r0), 32'd2);

        // Reset after five SRCLK rises: no latch pulse, previous word retained.
        @(posedge clk); #1;
        kept = latch_a;
        s0 = srclk_cnt_a; r0 = rclk_cnt_a;
        frame_a(8'h3C);
        c = 0;
        while ((srclk_cnt_a - s0) < 5 && c < 100) begin @(posedge clk); #1; c++; end
        chk("abort_reached_5", 32'(srclk_cnt_a - s0), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready_a), 32'd1);
        chk("abort_srclk", 32'(srclk_a), 32'd0);
        chk("abort_rclk",  32'(rclk_a),  32'd0);
        chk("abort_ser",   32'(ser_a),   32'd0);
`ifdef SHIFTREG_OE_EN
        chk("abort_oe", 32'(oe_a), 32'd1);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_rclk",   32'(rclk_cnt_a - r0), 32'd0);
        chk("abort_latch_kept", 32'(latch_a),        32'(kept));
        exp_bits_a.delete();
        exp_latch_a.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        r0 = rclk_cnt_a;
        frame_a(8'h5A);
        wait_ready_a(100, "after_abort");
        chk("after_abort_rclk",  32'(rclk_cnt_a - r0), 32'd1);
        chk("after_abort_latch", 32'(latch_a),         32'h5A);
`ifdef SHIFTREG_OE_EN
        chk("after_abort_oe", 32'(oe_a), 32'd0);
`endif

        chk("a_never_overlap", 32'(overlap_a),   32'd0);
        chk("b_never_overlap", 32'(overlap_b),   32'd0);
        chk("a_phase_timing",  32'(phase_err_a), 32'd0);
        chk("b_phase_timing",  32'(phase_err_b), 32'd0);
        chk("a_bits_drained",  32'(exp_bits_a.size()), 32'd0);
        chk("b_bits_drained",  32'(exp_bits_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
